// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// offsets and ICUR field layout.
package intr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  localparam logic [31:0] OFF_IPEND = 32'h0;
  localparam logic [31:0] OFF_IENAB = 32'h4;
  localparam logic [31:0] OFF_ICUR  = 32'h8;

  localparam int ICUR_VALID_BIT = 31;
  localparam int ICUR_ID_W      = 3;

  typedef logic [ICUR_ID_W-1:0] src_id_t;

  function automatic logic [31:0] icur_word(input logic valid, input src_id_t id);
    logic [31:0] w;
    w = '0;
    w[ICUR_VALID_BIT]  = valid;
    w[ICUR_ID_W-1:0]   = id;
    return w;
  endfunction

endpackage

// File: rtl/intr_arbiter.sv
// Winner selection: first requesting source found when scanning upward from
// ptr with wrap-around; ptr = 0 gives plain lowest-index priority.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  input  src_id_t         ptr,
  output src_id_t         id,
  output logic            any
);

  logic [NSRC-1:0] rot;
  int              sum;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    id  = '0;
    any = 1'b0;
    sum = 0;
    rot = NSRC'({req, req} >> ptr);
    for (int k = 0; k < NSRC; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = int'(ptr) + k;
        if (sum >= NSRC) sum = sum - NSRC;
        id = src_id_t'(sum);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller (IPEND/IENAB/ICUR) with an IDLE/REQ/SERVE
// handshake. Define INTR_RR_EN for round-robin instead of fixed priority.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter logic [31:0] BASE = 32'hF0000800,
  parameter int          NSRC = 4
) (
  input  logic            CLK,
  input  logic            INIT,
  input  logic [31:0]     ABUS,
  inout  wire  [31:0]     DBUS,
  input  logic            WE,
  input  logic [NSRC-1:0] IRQ,
  output logic [NSRC-1:0] IRQ_ACK,
  output logic            CPU_INTR,
  input  logic            CPU_INTA
);

  logic [1:0]      state;
  logic [NSRC-1:0] ipend;
  logic [NSRC-1:0] ienab;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] irq_ack_q;
  logic            icur_valid;
  src_id_t         icur_id;

  logic            hit_ipend, hit_ienab, hit_icur;
  logic            wr_ienab, wr_icur;
  logic            rd_hit;
  logic [31:0]     rd_data;
  logic [NSRC-1:0] irq_rise;
  logic [NSRC-1:0] ack_mask;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] pend_en;
  logic            ack_fire;
  src_id_t         win_id;
  logic            win_any;
  src_id_t         ptr;
  logic            unused_dbus;

  assign hit_ipend = (ABUS == BASE + OFF_IPEND);
  assign hit_ienab = (ABUS == BASE + OFF_IENAB);
  assign hit_icur  = (ABUS == BASE + OFF_ICUR);
  assign wr_ienab  = WE && hit_ienab;
  assign wr_icur   = WE && hit_icur;
  assign unused_dbus = ^DBUS[31:NSRC];

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (hit_ipend) begin
      rd_hit  = 1'b1;
      rd_data = 32'(ipend);
    end else if (hit_ienab) begin
      rd_hit  = 1'b1;
      rd_data = 32'(ienab);
    end else if (hit_icur) begin
      rd_hit  = 1'b1;
      rd_data = icur_word(icur_valid, icur_id);
    end
  end

  assign DBUS = (!WE && rd_hit) ? rd_data : 'z;

  assign irq_rise = IRQ & ~irq_q;
  assign ack_fire = (state == ST_REQ) && CPU_INTA;
  assign ack_mask = NSRC'(1) << icur_id;
  assign clr_mask = ack_fire ? ack_mask : '0;
  assign pend_en  = ipend & ienab;

  intr_arbiter #(.NSRC(NSRC)) u_arb (
    .req (pend_en),
    .ptr (ptr),
    .id  (win_id),
    .any (win_any)
  );

`ifdef INTR_RR_EN
  // Next search starts just past the source that was last acknowledged.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      ptr <= '0;
    end else if (ack_fire) begin
      ptr <= (icur_id == src_id_t'(NSRC - 1)) ? '0 : icur_id + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state      <= ST_IDLE;
      ipend      <= '0;
      ienab      <= '0;
      irq_q      <= '0;
      irq_ack_q  <= '0;
      icur_valid <= 1'b0;
      icur_id    <= '0;
    end else begin
      irq_q     <= IRQ;
      // A fresh edge outranks the acknowledge clear on the same bit.
      ipend     <= (ipend & ~clr_mask) | irq_rise;
      irq_ack_q <= clr_mask;
      if (wr_ienab) ienab <= DBUS[NSRC-1:0];
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            state      <= ST_REQ;
            icur_id    <= win_id;
            icur_valid <= 1'b1;
          end
        end
        ST_REQ: begin
          if (CPU_INTA) state <= ST_SERVE;
        end
        ST_SERVE: begin
          if (wr_icur) begin
            state      <= ST_IDLE;
            icur_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign CPU_INTR = (state == ST_REQ) && !INIT;
  assign IRQ_ACK  = irq_ack_q & {NSRC{!INIT}};

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: register table, directed handshake
// sequences and a randomized service loop against a pending-set model.
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam logic [31:0] BASE = 32'hF0000800;
  localparam int          NSRC = 4;
  localparam logic [31:0] IDLE_ADDR = 32'h0;

  logic        CLK = 1'b0;
  logic        INIT;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic        WE;
  logic [3:0]  IRQ;
  wire  [3:0]  IRQ_ACK;
  wire         CPU_INTR;
  logic        CPU_INTA;
  logic        drv;
  logic [31:0] wdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] mpend;
  int         mptr;

  assign DBUS = drv ? wdata : 'z;

  always #5 CLK = ~CLK;

  intr_ctrl #(.BASE(BASE), .NSRC(NSRC)) dut (
    .CLK      (CLK),
    .INIT     (INIT),
    .ABUS     (ABUS),
    .DBUS     (DBUS),
    .WE       (WE),
    .IRQ      (IRQ),
    .IRQ_ACK  (IRQ_ACK),
    .CPU_INTR (CPU_INTR),
    .CPU_INTA (CPU_INTA)
  );

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called just after a negedge; a read does not consume a clock edge.
  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    ABUS = BASE + off;
    WE   = 1'b0;
    #1;
    d    = DBUS;
    ABUS = IDLE_ADDR;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    ABUS  = BASE + off;
    WE    = 1'b1;
    wdata = data;
    drv   = 1'b1;
    @(negedge CLK);
    WE    = 1'b0;
    drv   = 1'b0;
    ABUS  = IDLE_ADDR;
  endtask

  task automatic do_reset();
    IRQ = '0; CPU_INTA = 1'b0;
    INIT = 1'b1;
    cyc(2);
    INIT = 1'b0;
    mpend = '0;
    mptr  = 0;
  endtask

  task automatic wait_intr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (CPU_INTR) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) check("intr_timeout", 32'(CPU_INTR), 32'd1);
  endtask

  // Rotate so the search origin sits at bit 0, isolate the lowest set bit.
  function automatic int pick(input logic [3:0] pe, input int p);
    logic [7:0] dbl;
    logic [3:0] r, iso;
    dbl = {pe, pe};
    r   = 4'(dbl >> p);
    iso = r & (~r + 4'd1);
    return ($clog2(int'(iso)) + p) % NSRC;
  endfunction

  initial begin
    bit ok;
    logic [31:0] d;
    int exp_id;
    logic [3:0] bits, en;
    int order[4];

    INIT = 1'b1; WE = 1'b0; ABUS = IDLE_ADDR; IRQ = '0; CPU_INTA = 1'b0;
    drv = 1'b0; wdata = '0;
    do_reset();

    // Register map after reset
    check("rst_cpu_intr", 32'(CPU_INTR), 32'd0);
    check("rst_irq_ack", 32'(IRQ_ACK), 32'd0);
    vt[0]  = '{1'b0, OFF_IPEND, 32'h0,         32'h0};
    vt[1]  = '{1'b0, OFF_IENAB, 32'h0,         32'h0};
    vt[2]  = '{1'b0, OFF_ICUR,  32'h0,         32'h0};
    vt[3]  = '{1'b1, OFF_IENAB, 32'hFFFF_FFF5, 32'h0};
    vt[4]  = '{1'b0, OFF_IENAB, 32'h0,         32'h5};
    vt[5]  = '{1'b1, OFF_IPEND, 32'hFFFF_FFFF, 32'h0};
    vt[6]  = '{1'b0, OFF_IPEND, 32'h0,         32'h0};
    vt[7]  = '{1'b1, OFF_ICUR,  32'h1,         32'h0};
    vt[8]  = '{1'b0, OFF_ICUR,  32'h0,         32'h0};
    vt[9]  = '{1'b1, OFF_IENAB, 32'h0,         32'h0};
    vt[10] = '{1'b0, OFF_IENAB, 32'h0,         32'h0};
    for (int i = 0; i < 11; i++) begin
      if (vt[i].we) wr(vt[i].off, vt[i].wdata);
      else begin
        rd(vt[i].off, d);
        check($sformatf("vec%0d", i), d, vt[i].exp);
      end
    end
    check("idle_no_intr", 32'(CPU_INTR), 32'd0);

    // Single source, full handshake
    do_reset();
    wr(OFF_IENAB, 32'h1);
    IRQ = 4'b0001;
    cyc(1);
    check("s1_intr_early", 32'(CPU_INTR), 32'd0);
    cyc(1);
    check("s1_intr", 32'(CPU_INTR), 32'd1);
    rd_chk("s1_icur", OFF_ICUR, 32'h8000_0000);
    CPU_INTA = 1'b1;
    cyc(1);
    CPU_INTA = 1'b0;
    check("s1_ack", 32'(IRQ_ACK), 32'h1);
    check("s1_serve_intr", 32'(CPU_INTR), 32'd0);
    rd_chk("s1_ipend_clr", OFF_IPEND, 32'h0);
    cyc(1);
    check("s1_ack_1cyc", 32'(IRQ_ACK), 32'h0);
    wr(OFF_ICUR, 32'h0);
    rd_chk("s1_eoi", OFF_ICUR, 32'h0);
    IRQ = '0;
    cyc(1);

    // Two simultaneous sources: id 1 before id 2
    do_reset();
    wr(OFF_IENAB, 32'hF);
    IRQ = 4'b0110;
    cyc(2);
    rd_chk("s2_first", OFF_ICUR, 32'h8000_0001);
    CPU_INTA = 1'b1; cyc(1); CPU_INTA = 1'b0;
    check("s2_ack1", 32'(IRQ_ACK), 32'h2);
    wr(OFF_ICUR, 32'h0);
    cyc(1);
    check("s2_intr2", 32'(CPU_INTR), 32'd1);
    rd_chk("s2_second", OFF_ICUR, 32'h8000_0002);
    CPU_INTA = 1'b1; cyc(1); CPU_INTA = 1'b0;
    check("s2_ack2", 32'(IRQ_ACK), 32'h4);
    wr(OFF_ICUR, 32'h0);
    IRQ = '0;

    // Pending while disabled, then enabled
    do_reset();
    IRQ = 4'b1000;
    cyc(2);
    rd_chk("s3_ipend", OFF_IPEND, 32'h8);
    check("s3_no_intr", 32'(CPU_INTR), 32'd0);
    wr(OFF_IENAB, 32'h8);
    cyc(1);
    check("s3_intr", 32'(CPU_INTR), 32'd1);
    rd_chk("s3_icur", OFF_ICUR, 32'h8000_0003);

    // EOI in REQ ignored; clearing IENAB in REQ keeps the request
    wr(OFF_ICUR, 32'h0);
    wr(OFF_IENAB, 32'h0);
    check("s3_req_kept", 32'(CPU_INTR), 32'd1);
    rd_chk("s3_icur_kept", OFF_ICUR, 32'h8000_0003);

    // Reset in SERVE: everything clears, no acknowledge
    CPU_INTA = 1'b1; cyc(1); CPU_INTA = 1'b0;
    cyc(1);
    IRQ  = '0;
    INIT = 1'b1;
    #1;
    check("s4_rst_intr", 32'(CPU_INTR), 32'd0);
    cyc(1);
    check("s4_rst_ack", 32'(IRQ_ACK), 32'h0);
    rd_chk("s4_ipend", OFF_IPEND, 32'h0);
    rd_chk("s4_ienab", OFF_IENAB, 32'h0);
    rd_chk("s4_icur", OFF_ICUR, 32'h0);
    INIT = 1'b0;
    cyc(1);
    check("s4_idle", 32'(CPU_INTR), 32'd0);

    // Reset together with accept in REQ: aborted, no pulse
    do_reset();
    wr(OFF_IENAB, 32'h1);
    IRQ = 4'b0001;
    cyc(2);
    CPU_INTA = 1'b1; INIT = 1'b1;
    cyc(1);
    check("s5_no_ack", 32'(IRQ_ACK), 32'h0);
    check("s5_no_intr", 32'(CPU_INTR), 32'd0);
    CPU_INTA = 1'b0; IRQ = '0;
    cyc(1);
    INIT = 1'b0;
    cyc(1);
    rd_chk("s5_icur", OFF_ICUR, 32'h0);

    // New edge on the acknowledging clock edge: set wins
    do_reset();
    wr(OFF_IENAB, 32'h1);
    IRQ = 4'b0001;
    cyc(1);
    IRQ = 4'b0000;
    cyc(1);
    IRQ = 4'b0001; CPU_INTA = 1'b1;
    cyc(1);
    CPU_INTA = 1'b0;
    check("s6_ack", 32'(IRQ_ACK), 32'h1);
    rd_chk("s6_ipend_kept", OFF_IPEND, 32'h1);
    wr(OFF_ICUR, 32'h0);
    cyc(1);
    check("s6_reintr", 32'(CPU_INTR), 32'd1);
    IRQ = '0;

`ifdef INTR_RR_EN
    // Round-robin with two continuously re-pending sources
    do_reset();
    order = '{0, 1, 0, 1};
    wr(OFF_IENAB, 32'h3);
    IRQ = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_intr(ok);
      if (!ok) break;
      rd_chk($sformatf("rr_order%0d", k), OFF_ICUR, 32'h8000_0000 | 32'(order[k]));
      IRQ = '0; CPU_INTA = 1'b1;
      cyc(1);
      CPU_INTA = 1'b0; IRQ = 4'b0011;
      wr(OFF_ICUR, 32'h0);
    end
    IRQ = '0;
`endif

    // Randomized rounds against the pending-set model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      wr(OFF_IENAB, 32'h0);
      bits = 4'($urandom_range(0, 15));
      IRQ = bits;
      cyc(1);
      IRQ = '0;
      cyc(1);
      mpend = mpend | bits;
      en = 4'($urandom_range(0, 15));
      wr(OFF_IENAB, 32'(en));
      rd_chk($sformatf("rnd%0d_ipend", r), OFF_IPEND, 32'(mpend));
      while ((mpend & en) != 0) begin
        wait_intr(ok);
        if (!ok) break;
        exp_id = pick(mpend & en, mptr);
        rd_chk($sformatf("rnd%0d_icur", r), OFF_ICUR, 32'h8000_0000 | 32'(exp_id));
        CPU_INTA = 1'b1; cyc(1); CPU_INTA = 1'b0;
        check($sformatf("rnd%0d_ack", r), 32'(IRQ_ACK), 32'(4'b0001 << exp_id));
        mpend[exp_id] = 1'b0;
`ifdef INTR_RR_EN
        mptr = (exp_id + 1) % NSRC;
`endif
        wr(OFF_ICUR, 32'h0);
      end
      if (!ok && (mpend & en) != 0) do_reset();
      cyc(1);
      check($sformatf("rnd%0d_quiet", r), 32'(CPU_INTR), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter BASE, default 32'hF0000800, byte address of the register block.
REQ-002 Parameter NSRC, default 4, number of interrupt sources; legal range 1..8.
REQ-003 Port CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 Port INIT  in  1  reset; synchronous and active-high.
REQ-005 Port ABUS  in  32  CPU byte address.
REQ-006 Port DBUS  inout  32  CPU data bus; driven only on a register read, high-Z otherwise.
REQ-007 Port WE  in  1  CPU write strobe; 1 = write, 0 = read.
REQ-008 Port IRQ  in  NSRC  device request levels, e.g. the timer's INTR on bit 0.
REQ-009 Port IRQ_ACK  out  NSRC  one-cycle acknowledge pulse to the serviced device.
REQ-010 Port CPU_INTR  out  1  interrupt request to the CPU.
REQ-011 Port CPU_INTA  in  1  CPU interrupt-accept strobe.

Function
REQ-012 Registers SHALL be IPEND at BASE+0 (read-only; writes ignored), IENAB at BASE+4 (read/write, bits [NSRC-1:0]), and ICUR at BASE+8 (read {valid, 28'b0, id[2:0]}; any write = end-of-interrupt, EOI).
REQ-013 Reads SHALL be combinational: DBUS = zero-extended register value while ABUS matches and WE=0.
REQ-014 IRQ SHALL be registered once per cycle; IPEND[i] SHALL set on a registered 0->1 edge of IRQ[i].
REQ-015 If an edge and an acknowledge hit the same IPEND bit in one cycle, set SHALL win.
REQ-016 The FSM SHALL have three states: IDLE, REQ and SERVE.
REQ-017 IDLE->REQ SHALL occur when (IPEND & IENAB) != 0; the arbiter winner is latched into ICUR.id and ICUR.valid is set to 1 in the same cycle.
REQ-018 In REQ, CPU_INTR SHALL be 1.
REQ-019 On the first cycle with CPU_INTA=1 in REQ, the FSM SHALL go REQ->SERVE; on that edge IRQ_ACK[id] is 1 for exactly one cycle and IPEND[id] is cleared.
REQ-020 In SERVE, CPU_INTR SHALL be 0; a write to ICUR moves SERVE->IDLE and clears ICUR.valid.
REQ-021 An EOI write in IDLE or REQ SHALL be ignored.
REQ-022 Clearing IENAB[id] while in REQ SHALL NOT cancel the latched request.
REQ-023 Minimum latency SHALL be one cycle: registered IRQ edge -> IPEND set -> CPU_INTR=1 on the next cycle.
REQ-024 Fixed-priority arbitration SHALL select the lowest pending-and-enabled index.

Reset
REQ-025 While INIT=1 at a clock edge, IPEND, IENAB, ICUR, the IRQ sample register and the round-robin pointer SHALL clear to 0 and the FSM SHALL go to IDLE.
REQ-026 During reset, CPU_INTR=0, IRQ_ACK=0 and DBUS is high-Z unless read-addressed.
REQ-027 INIT asserted in REQ or SERVE SHALL abort the service with no IRQ_ACK pulse.

Configuration
REQ-028 Macro INTR_RR_EN defined: round-robin arbitration; the search starts at pointer ptr, and ptr = id+1 (mod NSRC) on each acknowledge.
REQ-029 Macro INTR_RR_EN undefined: fixed priority per REQ-024; no pointer register is built.

Structure
REQ-030 Package intr_pkg SHALL hold the FSM state encoding, the register offsets (0, 4, 8) and the ICUR field positions.
REQ-031 Winner selection SHALL be the sub-module intr_arbiter: inputs req vector and ptr; outputs id and any.

Verification
REQ-032 Scenario: IENAB=4'b0001, IRQ[0] rises -> CPU_INTR=1 two cycles later; CPU_INTA -> IRQ_ACK=4'b0001 for one cycle; ICUR reads 32'h80000000.
REQ-033 Scenario: IRQ[2] and IRQ[1] rise together, all enabled, fixed priority -> id 1 serviced first; after EOI, id 2 serviced.
REQ-034 Scenario: INTR_RR_EN, sources 0 and 1 continuously re-pending -> service order 0,1,0,1.
REQ-035 Scenario: IENAB=0, IRQ[3] rises -> IPEND=4'b1000 and CPU_INTR stays 0; then write IENAB=4'b1000 -> CPU_INTR=1.
REQ-036 Scenario: INIT=1 while in SERVE -> next cycle all registers read 0, state IDLE, no IRQ_ACK pulse.
REQ-037 Scenario: new IRQ[0] edge in the same cycle as the IRQ_ACK[0] pulse -> IPEND[0] remains 1.
